// File: rtl/cpu_core.sv
// cpu_core: 8-bit multi-cycle CPU (fetch/decode/execute, 3 clocks per instruction) with four GPRs and 32-bit instructions.
// Optional build macro CPU_CYCLE_COUNTER_EN enables the free-running clks counter; otherwise clks is tied to zero.
module cpu_core #(
    parameter int RAM_SIZE = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RAM_SIZE*32-1:0] ram,
    output logic [7:0]             flags,
    output logic [7:0]             al,
    output logic [7:0]             bl,
    output logic [7:0]             cl,
    output logic [7:0]             dl,
    output logic [31:0]            ir,
    output logic [15:0]            clks,
    output logic [7:0]             pc,
    output logic [1:0]             state
);
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t      cur, nxt;
    logic [7:0]  gpr [4];
    logic [7:0]  op_a, op_b;
    logic [3:0]  flg;
    logic [3:0]  flg_next;
    logic [31:0] fetch_word;
    logic [3:0]  opc;
    logic [1:0]  dst;
    logic [8:0]  sum, diff;
    logic [7:0]  res, pc_next;
    logic        wr_en, flg_en;

    assign opc = ir[31:28];
    assign dst = ir[25:24];

    // Words beyond the end of program memory read as NOP.
    always_comb begin
        fetch_word = 32'h0;
        if (int'(pc) < RAM_SIZE)
            fetch_word = ram[int'(pc)*32 +: 32];
    end

    always_comb begin
        sum      = {1'b0, op_a} + {1'b0, op_b};
        diff     = {1'b0, op_a} - {1'b0, op_b};
        res      = 8'h00;
        flg_next = flg;
        wr_en    = 1'b0;
        flg_en   = 1'b0;
        pc_next  = pc + 8'd1;
        case (opc)
            4'h1: begin
                res   = op_b;
                wr_en = 1'b1;
            end
            4'h2: begin
                res         = sum[7:0];
                flg_next[1] = sum[8];
                flg_next[3] = (op_a[7] == op_b[7]) && (res[7] != op_a[7]);
                wr_en       = 1'b1;
                flg_en      = 1'b1;
            end
            4'h3, 4'h7: begin
                // diff[8] is the borrow: set when A < B unsigned
                res         = diff[7:0];
                flg_next[1] = diff[8];
                flg_next[3] = (op_a[7] != op_b[7]) && (res[7] != op_a[7]);
                wr_en       = (opc == 4'h3);
                flg_en      = 1'b1;
            end
            4'h4, 4'h5, 4'h6: begin
                case (opc)
                    4'h4:    res = op_a & op_b;
                    4'h5:    res = op_a | op_b;
                    default: res = op_a ^ op_b;
                endcase
                flg_next[1] = 1'b0;
                flg_next[3] = 1'b0;
                wr_en       = 1'b1;
                flg_en      = 1'b1;
            end
            4'h8: pc_next = op_b;
            4'h9: if (flg[0])  pc_next = op_b;
            4'hA: if (!flg[0]) pc_next = op_b;
            4'hB: if (flg[1])  pc_next = op_b;
            default: ;
        endcase
        if (flg_en) begin
            flg_next[0] = (res == 8'h00);
            flg_next[2] = res[7];
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:   nxt = DECODE;
            DECODE:  nxt = EXECUTE;
            EXECUTE: nxt = (opc == 4'hF) ? HALT : FETCH;
            default: nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cur <= FETCH;
        else
            cur <= nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir   <= 32'h0;
            pc   <= 8'h00;
            flg  <= 4'h0;
            op_a <= 8'h00;
            op_b <= 8'h00;
            for (int i = 0; i < 4; i++)
                gpr[i] <= 8'h00;
        end else begin
            case (cur)
                FETCH: ir <= fetch_word;
                DECODE: begin
                    // Operands are captured here so same-register forms see pre-execute values.
                    op_a <= gpr[dst];
                    op_b <= ir[27] ? ir[7:0] : gpr[ir[17:16]];
                end
                EXECUTE: begin
                    if (wr_en)
                        gpr[dst] <= res;
                    flg <= flg_next;
                    pc  <= pc_next;
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_CYCLE_COUNTER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            clks <= 16'h0000;
        else
            clks <= clks + 16'd1;
    end
`else
    assign clks = 16'h0000;
`endif

    assign flags = {4'b0000, flg};
    assign al    = gpr[0];
    assign bl    = gpr[1];
    assign cl    = gpr[2];
    assign dl    = gpr[3];
    assign state = cur;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: an instruction-level reference model fills a scoreboard queue;
// a monitor pops one entry each time the core retires an instruction.
`timescale 1ns/1ps
module tb_cpu_core;
    localparam int RS = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [RS*32-1:0]  ram = '0;
    logic [7:0]        flags, al, bl, cl, dl, pc;
    logic [31:0]       ir;
    logic [15:0]       clks;
    logic [1:0]        state;

    cpu_core #(.RAM_SIZE(RS)) dut (
        .clk(clk), .reset(reset), .ram(ram), .flags(flags),
        .al(al), .bl(bl), .cl(cl), .dl(dl), .ir(ir),
        .clks(clks), .pc(pc), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  r0, r1, r2, r3;
        logic [7:0]  fl;
        logic [7:0]  pc;
        logic [1:0]  st;
        logic [31:0] ir;
    } exp_t;

    exp_t        q[$];
    exp_t        last_exp;
    logic [31:0] mem [RS];
    int          total = 0;
    int          bad = 0;
    logic [15:0] cyc;
    logic [1:0]  prev_st = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 16'h0;
        else        cyc <= cyc + 16'd1;
    end

    function automatic logic [15:0] exp_clks();
`ifdef CPU_CYCLE_COUNTER_EN
        return cyc;
`else
        return 16'h0;
`endif
    endfunction

    // Reference interpreter: plain integer arithmetic over the instruction set.
    task automatic model_run(input int n);
        int          mr[4];
        int          mpc, npc, op, d, a, b, sa, sb, r, sr;
        bit          mz, mc, ms, mv, alu;
        logic [31:0] w;
        logic [1:0]  st;
        exp_t        e;
        mr = '{0, 0, 0, 0};
        mpc = 0; mz = 0; mc = 0; ms = 0; mv = 0;
        for (int k = 0; k < n; k++) begin
            w   = (mpc < RS) ? mem[mpc] : 32'h0;
            op  = int'(w[31:28]);
            d   = int'(w[25:24]);
            a   = mr[d];
            b   = w[27] ? int'(w[7:0]) : mr[w[17:16]];
            sa  = (a > 127) ? a - 256 : a;
            sb  = (b > 127) ? b - 256 : b;
            npc = (mpc + 1) % 256;
            st  = 2'd0;
            alu = 0;
            r   = 0;
            case (op)
                1: mr[d] = b;
                2: begin
                    r = a + b; mc = (r > 255); r = r % 256;
                    sr = sa + sb; mv = (sr > 127) || (sr < -128);
                    mr[d] = r; alu = 1;
                end
                3, 7: begin
                    r = (a - b + 256) % 256; mc = (a < b);
                    sr = sa - sb; mv = (sr > 127) || (sr < -128);
                    if (op == 3) mr[d] = r;
                    alu = 1;
                end
                4, 5, 6: begin
                    r = (op == 4) ? (a & b) : (op == 5) ? (a | b) : (a ^ b);
                    mc = 0; mv = 0; mr[d] = r; alu = 1;
                end
                8:  npc = b;
                9:  if (mz)  npc = b;
                10: if (!mz) npc = b;
                11: if (mc)  npc = b;
                15: st = 2'd3;
                default: ;
            endcase
            if (alu) begin
                mz = (r == 0);
                ms = (r > 127);
            end
            mpc  = npc;
            e.r0 = 8'(mr[0]); e.r1 = 8'(mr[1]); e.r2 = 8'(mr[2]); e.r3 = 8'(mr[3]);
            e.fl = {4'b0, mv, ms, mc, mz};
            e.pc = 8'(mpc);
            e.st = st;
            e.ir = w;
            q.push_back(e);
            last_exp = e;
            if (st == 2'd3) break;
        end
    endtask

    // Monitor: a retired instruction shows up as EXECUTE followed by FETCH or HALT.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prev_st = 2'd0;
        end else begin
            if (prev_st == 2'd2 && state != 2'd2) begin
                if (q.size() == 0) begin
                    chk("retire_unexpected", 32'(pc), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("al", 32'(al), 32'(e.r0));
                    chk("bl", 32'(bl), 32'(e.r1));
                    chk("cl", 32'(cl), 32'(e.r2));
                    chk("dl", 32'(dl), 32'(e.r3));
                    chk("flags", 32'(flags), 32'(e.fl));
                    chk("pc", 32'(pc), 32'(e.pc));
                    chk("state", 32'(state), 32'(e.st));
                    chk("ir", ir, e.ir);
                    chk("clks", 32'(clks), 32'(exp_clks()));
                end
            end
            prev_st = state;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_al"}, 32'(al), 0);
        chk({tag, "_bl"}, 32'(bl), 0);
        chk({tag, "_cl"}, 32'(cl), 0);
        chk({tag, "_dl"}, 32'(dl), 0);
        chk({tag, "_flags"}, 32'(flags), 0);
        chk({tag, "_ir"}, ir, 0);
        chk({tag, "_pc"}, 32'(pc), 0);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_clks"}, 32'(clks), 0);
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (q.size() != 0 && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk("drain_left", 32'(q.size()), 0);
        q.delete();
    endtask

    task automatic load_ram();
        for (int i = 0; i < RS; i++)
            ram[i*32 +: 32] = mem[i];
    endtask

    task automatic start_prog(input int n, input bit first_chk, input bit drain);
        reset = 1'b0;
        q.delete();
        load_ram();
        model_run(n);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        if (first_chk) begin
            @(posedge clk); #1;
            chk("clk1_state", 32'(state), 1);
            chk("clk1_ir", ir, mem[0]);
            @(posedge clk); @(posedge clk); #1;
            chk("clk3_pc", 32'(pc), 1);
            chk("clk3_state", 32'(state), 0);
        end
        if (drain) wait_drain(n * 3 + 20);
    endtask

    task automatic fill_random();
        logic [31:0] w;
        int          op;
        for (int i = 0; i < RS; i++) begin
            w  = $urandom;
            op = $urandom_range(0, 15);
            w[31:28] = 4'(op);
            if (op >= 8 && op <= 11 && w[27])
                w[7:0] = 8'($urandom_range(0, 17));
            mem[i] = w;
        end
    endtask

    initial begin
        for (int i = 0; i < RS; i++) mem[i] = 32'h0;
        #2 reset = 1'b0;
        #1 check_zero("reset");

        // MOV al,#5 ; MOV bl,al ; JMP #0 looping
        mem[0] = 32'h1800_0005;
        mem[1] = 32'h1100_0000;
        mem[2] = 32'h8800_0000;
        for (int i = 3; i < RS; i++) mem[i] = 32'h2B00_0001;
        start_prog(9, 1'b1, 1'b1);

        // Arithmetic / flag sequence with conditional branches, ending in HLT
        mem[0]  = 32'h1800_00F0;
        mem[1]  = 32'h2800_0020;
        mem[2]  = 32'h3800_0010;
        mem[3]  = 32'h3800_0001;
        mem[4]  = 32'h1A00_0080;
        mem[5]  = 32'h3A00_0001;
        mem[6]  = 32'h6202_0000;
        mem[7]  = 32'h7B00_0000;
        mem[8]  = 32'h9800_000C;
        mem[9]  = 32'h5D00_00FF;
        mem[10] = 32'h1BAA_5533;
        mem[11] = 32'hF000_0000;
        mem[12] = 32'hA800_0002;
        mem[13] = 32'hF000_0000;
        mem[14] = 32'h0;
        mem[15] = 32'h0;
        start_prog(20, 1'b0, 1'b1);

        // HLT at word 2: everything but clks holds
        fill_random();
        mem[0] = 32'h1800_0005;
        mem[1] = 32'h2800_0003;
        mem[2] = 32'hF000_0000;
        start_prog(10, 1'b0, 1'b1);
        repeat (25) @(negedge clk);
        #1;
        chk("halt_state", 32'(state), 3);
        chk("halt_pc", 32'(pc), 32'(last_exp.pc));
        chk("halt_ir", ir, last_exp.ir);
        chk("halt_al", 32'(al), 32'(last_exp.r0));
        chk("halt_flags", 32'(flags), 32'(last_exp.fl));
        chk("halt_clks", 32'(clks), 32'(exp_clks()));

        // Randomized programs, including jumps past the end of memory
        for (int p = 0; p < 8; p++) begin
            fill_random();
            start_prog(30, 1'b0, 1'b1);
        end

        // Asynchronous reset in the middle of an instruction
        fill_random();
        for (int i = 0; i < RS; i++)
            if (mem[i][31:28] == 4'hF) mem[i][31:28] = 4'h1;
        start_prog(40, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        q.delete();
        reset = 1'b0;
        #1 check_zero("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
